// File: rtl/rle_pkg.sv
// Shared types and field positions for the CD-i CLUT run-length line decoder.
package rle_pkg;

    typedef enum logic {
        RLE_MODE_RL7 = 1'b0,
        RLE_MODE_RL3 = 1'b1
    } rle_mode_t;

    localparam int RLE_RUN_BIT = 7;
    localparam int RL3_P0_LSB  = 4;
    localparam int RL3_P1_LSB  = 0;

    function automatic logic [7:0] rl7_pixel(input logic [7:0] b);
        return {1'b0, b[6:0]};
    endfunction

    function automatic logic [7:0] rl3_pixel(input logic [7:0] b, input int lsb);
        return {5'b00000, b[lsb +: 3]};
    endfunction

endpackage

// File: rtl/rle_out_stage.sv
// One-entry registered valid/ready slice carrying a CLUT index and its end-of-line flag.
module rle_out_stage (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_flush,
    input  logic       i_load,
    input  logic [7:0] i_pixel,
    input  logic       i_last,
    input  logic       i_ready,
    output logic [7:0] o_pixel,
    output logic       o_last,
    output logic       o_valid,
    output logic       o_free
);

    logic [7:0] r_pixel;
    logic       r_last;
    logic       r_valid;

    // Holding register: flush drops the beat, load overwrites, handshake empties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel <= 8'h00;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_pixel <= 8'h00;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pixel <= i_pixel;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_free  = !r_valid || i_ready;
    assign o_pixel = r_pixel;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule

// File: rtl/rle_line_decoder.sv
// RL7/RL3 run-length decoder producing one CLUT index per beat, clamped to LINE_WIDTH pixels.
module rle_line_decoder
    import rle_pkg::*;
#(
    parameter int LINE_WIDTH = 384,
    parameter int XW         = $clog2(LINE_WIDTH + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  rle_mode_t  mode,
    input  logic       line_start,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    output logic [7:0] dst_pixel,
    output logic       dst_valid,
    input  logic       dst_ready,
    output logic       dst_last,
    output logic       line_done,
    output logic       overrun
);

    localparam int            AW      = (XW > 9) ? XW : 9;
    localparam logic [XW-1:0] X_LAST  = XW'(LINE_WIDTH - 1);
    localparam logic [XW-1:0] X_ONE   = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] A_WIDTH = AW'(LINE_WIDTH);
    localparam logic [AW-1:0] A_ONE   = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLOR    = 3'd1,
        ST_COUNT    = 3'd2,
        ST_EMIT     = 3'd3,
        ST_LINE_END = 3'd4
    } state_t;

    state_t        r_state;
    rle_mode_t     r_mode;
    logic [XW-1:0] r_x;
    logic [AW-1:0] r_rem;
    logic [7:0]    r_p0;
    logic [7:0]    r_p1;
    logic          r_phase;
    logic          r_overrun;
    logic          r_line_done;

    logic          w_out_free;
    logic          w_src_ready;
    logic          w_src_fire;
    logic          w_at_end;
    logic          w_load;
    logic          w_req_over;
    logic [7:0]    w_pix;
    logic [7:0]    w_lit_px;
    logic [7:0]    w_run_px;
    logic [AW-1:0] w_avail;
    logic [AW-1:0] w_req;
    logic [AW-1:0] w_total;

    // Source handshake, run-length arithmetic and next output beat selection.
    always_comb begin
        case (r_state)
            ST_COLOR: w_src_ready = w_out_free && !line_start;
            ST_COUNT: w_src_ready = !line_start;
            default:  w_src_ready = 1'b0;
        endcase
        w_src_fire = src_valid && w_src_ready;
        w_at_end   = (r_x == X_LAST);
        w_lit_px   = (r_mode == RLE_MODE_RL7) ? rl7_pixel(src_data) : rl3_pixel(src_data, RL3_P0_LSB);
        w_run_px   = (r_mode == RLE_MODE_RL3 && r_phase) ? r_p1 : r_p0;
        w_avail    = A_WIDTH - AW'(r_x);
        w_req      = (r_mode == RLE_MODE_RL7) ? AW'(src_data) : AW'({src_data, 1'b0});
        // A zero count means "fill to end of line", so it can never overrun.
        w_req_over = (src_data != 8'h00) && (w_req > w_avail);
        w_total    = (src_data == 8'h00 || w_req_over) ? w_avail : w_req;
        case (r_state)
            ST_COLOR: begin
                w_load = w_src_fire && !src_data[RLE_RUN_BIT];
                w_pix  = w_lit_px;
            end
            ST_COUNT: begin
                w_load = w_src_fire && w_out_free;
                w_pix  = w_run_px;
            end
            ST_EMIT: begin
                w_load = w_out_free && !line_start;
                w_pix  = w_run_px;
            end
            default: begin
                w_load = 1'b0;
                w_pix  = 8'h00;
            end
        endcase
    end

    // Line sequencer: position, remaining run length, latched colours and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= RLE_MODE_RL7;
            r_x         <= '0;
            r_rem       <= '0;
            r_p0        <= 8'h00;
            r_p1        <= 8'h00;
            r_phase     <= 1'b0;
            r_overrun   <= 1'b0;
            r_line_done <= 1'b0;
        end else if (line_start) begin
            r_state     <= ST_COLOR;
            r_mode      <= mode;
            r_x         <= '0;
            r_rem       <= '0;
            r_phase     <= 1'b0;
            r_overrun   <= 1'b0;
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= 1'b0;
            if (w_load) begin
                r_x <= r_x + X_ONE;
            end
            case (r_state)
                ST_COLOR: begin
                    if (w_src_fire) begin
                        if (src_data[RLE_RUN_BIT]) begin
                            r_p0    <= w_lit_px;
                            r_p1    <= rl3_pixel(src_data, RL3_P1_LSB);
                            r_phase <= 1'b0;
                            r_state <= ST_COUNT;
                        end else if (w_at_end) begin
                            r_state <= ST_LINE_END;
                        end else if (r_mode == RLE_MODE_RL3) begin
                            r_p1    <= rl3_pixel(src_data, RL3_P1_LSB);
                            r_phase <= 1'b1;
                            r_rem   <= A_ONE;
                            r_state <= ST_EMIT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (w_src_fire) begin
                        if (w_req_over) begin
                            r_overrun <= 1'b1;
                        end
                        // The first run pixel goes out with the count byte when the slice is free.
                        if (w_out_free) begin
                            r_phase <= !r_phase;
                            r_rem   <= w_total - A_ONE;
                            if (w_at_end) begin
                                r_state <= ST_LINE_END;
                            end else if (w_total == A_ONE) begin
                                r_state <= ST_COLOR;
                            end else begin
                                r_state <= ST_EMIT;
                            end
                        end else begin
                            r_rem   <= w_total;
                            r_state <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_out_free) begin
                        r_phase <= !r_phase;
                        r_rem   <= r_rem - A_ONE;
                        if (w_at_end) begin
                            r_state <= ST_LINE_END;
                        end else if (r_rem == A_ONE) begin
                            r_state <= ST_COLOR;
                        end
                    end
                end
                ST_LINE_END: begin
                    if (dst_valid && dst_ready) begin
                        r_line_done <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    rle_out_stage u_out (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (line_start),
        .i_load  (w_load),
        .i_pixel (w_pix),
        .i_last  (w_at_end),
        .i_ready (dst_ready),
        .o_pixel (dst_pixel),
        .o_last  (dst_last),
        .o_valid (dst_valid),
        .o_free  (w_out_free)
    );

    assign src_ready = w_src_ready;
    assign line_done = r_line_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_rle_line_decoder.sv
// Directed and randomised line decoding against a byte-stream expansion model.
module tb_rle_line_decoder;
    import rle_pkg::*;

    localparam int LW = 8;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    rle_mode_t  mode = RLE_MODE_RL7;
    logic       line_start = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic [7:0] dst_pixel;
    logic       dst_valid;
    logic       dst_ready = 1'b0;
    logic       dst_last;
    logic       line_done;
    logic       overrun;

    int   n_assert = 0;
    int   n_fail = 0;
    bq_t  src_q;
    int   src_idx = 0;
    bq_t  got_q;
    bit   got_last[$];
    int   ready_pct = 100;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_pix = 8'h00;
    logic prev_last = 1'b0;
    bit   prev_last_fire = 1'b0;
    bit   done_seen = 1'b0;

    rle_line_decoder #(.LINE_WIDTH(LW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .line_start (line_start),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .dst_pixel  (dst_pixel),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .dst_last   (dst_last),
        .line_done  (line_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expands codes into the pixel list a line of LW pixels would show.
    task automatic ref_model(input rle_mode_t m, input bq_t b, output bq_t px, output bit ov);
        int i;
        int room;
        int req;
        logic [7:0] a;
        logic [7:0] c0;
        logic [7:0] c1;
        px = {};
        ov = 1'b0;
        i = 0;
        while (i < b.size() && px.size() < LW) begin
            a = b[i];
            i++;
            c0 = (m == RLE_MODE_RL7) ? {1'b0, a[6:0]} : {5'b00000, a[6:4]};
            c1 = (m == RLE_MODE_RL7) ? c0 : {5'b00000, a[2:0]};
            if (!a[7]) begin
                px.push_back(c0);
                if (m == RLE_MODE_RL3) px.push_back(c1);
            end else if (i < b.size()) begin
                room = LW - px.size();
                req = (b[i] == 8'h00) ? room : ((m == RLE_MODE_RL7) ? int'(b[i]) : 2 * int'(b[i]));
                i++;
                if (req > room) ov = 1'b1;
                for (int j = 0; j < req && px.size() < LW; j++)
                    px.push_back((m == RLE_MODE_RL3 && (j % 2) == 1) ? c1 : c0);
            end
        end
        while (px.size() > LW) void'(px.pop_back());
    endtask

    task automatic gen_line(input rle_mode_t m, output bq_t b);
        bq_t px;
        bit  ov;
        b = {};
        do begin
            if ($urandom_range(1) == 0) begin
                b.push_back(8'($urandom_range(127)));
            end else begin
                b.push_back(8'($urandom_range(255, 128)));
                b.push_back(($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(4)));
            end
            ref_model(m, b, px, ov);
        end while (px.size() < LW);
    endtask

    // One clock: sample at negedge, drive, then record handshakes just before the next posedge.
    task automatic step();
        bit sfire;
        bit dfire;
        @(negedge clk);
        check("line_done", line_done, prev_last_fire);
        done_seen = done_seen | line_done;
        dst_ready = ($urandom_range(99) < ready_pct);
        src_valid = (src_idx < src_q.size());
        src_data  = src_valid ? src_q[src_idx] : 8'h00;
        #1;
        if (prev_stall) begin
            check("hold_valid", dst_valid, 1'b1);
            check("hold_pixel", dst_pixel, prev_pix);
            check("hold_last", dst_last, prev_last);
        end
        dfire = dst_valid && dst_ready;
        sfire = src_valid && src_ready;
        prev_stall = dst_valid && !dst_ready;
        prev_pix = dst_pixel;
        prev_last = dst_last;
        prev_last_fire = dfire && dst_last;
        if (dfire) begin
            got_q.push_back(dst_pixel);
            got_last.push_back(dst_last);
        end
        if (sfire) src_idx++;
    endtask

    task automatic start_line(input rle_mode_t m);
        @(negedge clk);
        mode = m;
        line_start = 1'b1;
        dst_ready = 1'b0;
        src_valid = 1'b1;
        src_data = 8'h05;
        #1;
        check("ls_src_ready", src_ready, 1'b0);
        @(negedge clk);
        line_start = 1'b0;
        src_valid = 1'b0;
        mode = (m == RLE_MODE_RL7) ? RLE_MODE_RL3 : RLE_MODE_RL7;
        #1;
        check("ls_valid", dst_valid, 1'b0);
        check("ls_last", dst_last, 1'b0);
        check("ls_overrun", overrun, 1'b0);
        got_q = {};
        got_last = {};
        src_q = {};
        src_idx = 0;
        prev_stall = 1'b0;
        prev_last_fire = 1'b0;
        done_seen = 1'b0;
    endtask

    task automatic run_line(input rle_mode_t m, input bq_t bytes, input bq_t exp, input bit ovr, input int pct);
        start_line(m);
        src_q = bytes;
        ready_pct = pct;
        for (int c = 0; c < 400 && !done_seen; c++) step();
        check("done_seen", done_seen, 1'b1);
        check("pix_count", got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            check("pixel", got_q[i], exp[i]);
            check("last", got_last[i], (i == LW - 1));
        end
        check("overrun", overrun, ovr);
        @(negedge clk);
        src_valid = 1'b1;
        src_data = 8'h05;
        dst_ready = 1'b1;
        #1;
        check("idle_src_ready", src_ready, 1'b0);
        check("idle_valid", dst_valid, 1'b0);
        check("done_pulse", line_done, 1'b0);
        src_valid = 1'b0;
    endtask

    initial begin
        bq_t b1, e1, b2, e2, b4, e4, b;
        bq_t e;
        bit  ov;
        rle_mode_t m;

        repeat (2) @(negedge clk);
        check("rst_valid", dst_valid, 1'b0);
        check("rst_pixel", dst_pixel, 8'h00);
        check("rst_last", dst_last, 1'b0);
        check("rst_done", line_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_src_ready", src_ready, 1'b0);
        reset_n = 1'b1;

        b1 = {8'h05, 8'h83, 8'h03, 8'h07, 8'h81, 8'h00};
        e1 = {8'h05, 8'h03, 8'h03, 8'h03, 8'h07, 8'h01, 8'h01, 8'h01};
        b2 = {8'h12, 8'hB4, 8'h02, 8'h56};
        e2 = {8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h04, 8'h05, 8'h06};
        b4 = {8'h81, 8'h0A};
        e4 = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};

        run_line(RLE_MODE_RL7, b1, e1, 1'b0, 100);
        run_line(RLE_MODE_RL3, b2, e2, 1'b0, 100);
        run_line(RLE_MODE_RL7, b1, e1, 1'b0, 50);
        run_line(RLE_MODE_RL3, b2, e2, 1'b0, 50);

        run_line(RLE_MODE_RL7, b4, e4, 1'b1, 100);
        repeat (3) begin
            @(negedge clk);
            src_valid = 1'b1;
            #1;
            check("ovr_src_ready", src_ready, 1'b0);
            check("ovr_sticky", overrun, 1'b1);
        end
        src_valid = 1'b0;

        // line_start three pixels into a fill run
        start_line(RLE_MODE_RL7);
        src_q = {8'h81, 8'h00};
        ready_pct = 100;
        for (int c = 0; c < 50 && got_q.size() < 3; c++) step();
        check("mid_prefix", got_q.size(), 3);
        run_line(RLE_MODE_RL3, b2, e2, 1'b0, 100);

        repeat (20) begin
            m = ($urandom_range(1) == 1) ? RLE_MODE_RL3 : RLE_MODE_RL7;
            gen_line(m, b);
            ref_model(m, b, e, ov);
            run_line(m, b, e, ov, ($urandom_range(1) == 1) ? 50 : 100);
        end

        // asynchronous reset in the middle of a run
        start_line(RLE_MODE_RL7);
        src_q = {8'h81, 8'h00};
        ready_pct = 100;
        for (int c = 0; c < 50 && got_q.size() < 3; c++) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", dst_valid, 1'b0);
        check("arst_pixel", dst_pixel, 8'h00);
        check("arst_last", dst_last, 1'b0);
        check("arst_done", line_done, 1'b0);
        check("arst_overrun", overrun, 1'b0);
        check("arst_src_ready", src_ready, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            src_valid = 1'b1;
            src_data = 8'h05;
            dst_ready = 1'b1;
            #1;
            check("arst_idle_ready", src_ready, 1'b0);
            check("arst_idle_valid", dst_valid, 1'b0);
        end
        src_valid = 1'b0;
        run_line(RLE_MODE_RL7, b1, e1, 1'b0, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
